// File: rtl/packet_demux.sv
// packet_demux: steers each AXI-Stream packet to one of M_COUNT master ports through a one-beat
// register slice. Define PACKET_DEMUX_DROP_EN to discard packets whose select is out of range.
module packet_demux #(
    parameter int M_COUNT     = 2,
    parameter int SELECT_SIZE = $clog2(M_COUNT),
    parameter int DATA_W      = 512,
    parameter int USER_W      = 48
) (
    input  logic                        axis_aclk,
    input  logic                        axis_rst,
    input  logic [SELECT_SIZE-1:0]      select,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    input  logic [DATA_W-1:0]           s_axis_tdata,
    input  logic [DATA_W/8-1:0]         s_axis_tkeep,
    input  logic [USER_W-1:0]           s_axis_tuser,
    output logic [M_COUNT-1:0]          m_axis_tvalid,
    input  logic [M_COUNT-1:0]          m_axis_tready,
    output logic [M_COUNT-1:0]          m_axis_tlast,
    output logic [M_COUNT*DATA_W-1:0]   m_axis_tdata,
    output logic [M_COUNT*DATA_W/8-1:0] m_axis_tkeep,
    output logic [M_COUNT*USER_W-1:0]   m_axis_tuser,
    output logic [SELECT_SIZE-1:0]      active_sel,
    output logic                        busy
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;
    localparam logic [SELECT_SIZE:0] PORT_LIMIT = (SELECT_SIZE+1)'(M_COUNT);

    logic [0:0]             state;
    logic                   out_valid;
    logic [SELECT_SIZE-1:0] out_port;
    logic                   out_last;
    logic [DATA_W-1:0]      out_data;
    logic [DATA_W/8-1:0]    out_keep;
    logic [USER_W-1:0]      out_user;

    logic [SELECT_SIZE-1:0] cur_sel;
    logic [SELECT_SIZE-1:0] route_port;
    logic                   sel_in_range;
    logic                   drop_beat;
    logic                   port_ready;
    logic                   s_fire;

    // First beat of a packet takes select live; later beats reuse the latched index.
    always_comb begin
        cur_sel      = (state == ST_IDLE) ? select : active_sel;
        sel_in_range = ({1'b0, cur_sel} < PORT_LIMIT);
`ifdef PACKET_DEMUX_DROP_EN
        route_port   = cur_sel;
        drop_beat    = !sel_in_range;
`else
        route_port   = sel_in_range ? cur_sel : '0;
        drop_beat    = 1'b0;
`endif
    end

    always_comb begin
        m_axis_tvalid = '0;
        for (int i = 0; i < M_COUNT; i++)
            m_axis_tvalid[i] = out_valid && (out_port == SELECT_SIZE'(i));
    end

    assign port_ready    = |(m_axis_tvalid & m_axis_tready);
    assign s_axis_tready = !axis_rst && (!out_valid || port_ready);
    assign s_fire        = s_axis_tvalid && s_axis_tready;
    assign busy          = (state == ST_BUSY);

    always_ff @(posedge axis_aclk) begin
        if (axis_rst) begin
            state      <= ST_IDLE;
            active_sel <= '0;
            out_valid  <= 1'b0;
            out_port   <= '0;
        end else begin
            if (s_fire) begin
                if (state == ST_IDLE)
                    active_sel <= route_port;
                state <= s_axis_tlast ? ST_IDLE : ST_BUSY;
            end
            if (s_fire && !drop_beat) begin
                out_valid <= 1'b1;
                out_port  <= route_port;
            end else if (port_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Payload is qualified by out_valid, so it carries no reset.
    always_ff @(posedge axis_aclk) begin
        if (s_fire && !drop_beat) begin
            out_data <= s_axis_tdata;
            out_keep <= s_axis_tkeep;
            out_user <= s_axis_tuser;
            out_last <= s_axis_tlast;
        end
    end

    for (genvar i = 0; i < M_COUNT; i++) begin : g_port
        assign m_axis_tdata[i*DATA_W +: DATA_W]     = out_data;
        assign m_axis_tkeep[i*DATA_W/8 +: DATA_W/8] = out_keep;
        assign m_axis_tuser[i*USER_W +: USER_W]     = out_user;
        assign m_axis_tlast[i]                      = out_last;
    end
endmodule

// File: tb/tb_packet_demux.sv
// Self-checking bench for packet_demux: directed scenarios plus a random run, all scored
// against a transaction-level model of packet routing and the single held output beat.
module tb_packet_demux;
    localparam int M  = 3;
    localparam int SS = 2;
    localparam int DW = 64;
    localparam int UW = 8;
    localparam int KW = DW/8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [SS-1:0] sel;
    logic          s_valid, s_ready, s_last;
    logic [DW-1:0] s_data;
    logic [KW-1:0] s_keep;
    logic [UW-1:0] s_user;
    logic [M-1:0]  m_valid, m_ready, m_last;
    logic [M*DW-1:0] m_data;
    logic [M*KW-1:0] m_keep;
    logic [M*UW-1:0] m_user;
    logic [SS-1:0] active_sel;
    logic          busy;

    packet_demux #(.M_COUNT(M), .SELECT_SIZE(SS), .DATA_W(DW), .USER_W(UW)) dut (
        .axis_aclk(clk), .axis_rst(rst), .select(sel),
        .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tlast(s_last),
        .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tuser(s_user),
        .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tlast(m_last),
        .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tuser(m_user),
        .active_sel(active_sel), .busy(busy)
    );

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    beat_t         held[$];
    bit            in_pkt = 0;
    bit            pkt_drop = 0;
    int            pkt_port = 0;
    logic [SS-1:0] exp_asel = '0;
    int            delivered[M];
    bit            acc;
    int            tests = 0;
    int            failed = 0;

    // One clock: compare DUT against the model at the falling edge, then advance the model.
    task automatic step();
        logic         exp_ready;
        logic [M-1:0] exp_valid;
        @(negedge clk);
        exp_ready = !rst && (held.size() == 0 || m_ready[held[0].port]);
        exp_valid = '0;
        if (held.size() != 0) exp_valid[held[0].port] = 1'b1;
        tests++;
        if (s_ready !== exp_ready) begin
            failed++; $display("FAIL s_tready: got %b want %b at %0t", s_ready, exp_ready, $time);
        end
        tests++;
        if (m_valid !== exp_valid) begin
            failed++; $display("FAIL m_tvalid: got %b want %b at %0t", m_valid, exp_valid, $time);
        end
        tests++;
        if (busy !== in_pkt) begin
            failed++; $display("FAIL busy: got %b want %b at %0t", busy, in_pkt, $time);
        end
        tests++;
        if (active_sel !== exp_asel) begin
            failed++; $display("FAIL active_sel: got %0d want %0d at %0t", active_sel, exp_asel, $time);
        end
        if (held.size() != 0) begin
            for (int p = 0; p < M; p++) begin
                tests++;
                if (m_data[p*DW +: DW] !== held[0].data || m_keep[p*KW +: KW] !== held[0].keep ||
                    m_user[p*UW +: UW] !== held[0].user || m_last[p] !== held[0].last) begin
                    failed++;
                    $display("FAIL payload slice %0d: got %h/%h/%h/%b want %h/%h/%h/%b at %0t", p,
                             m_data[p*DW +: DW], m_keep[p*KW +: KW], m_user[p*UW +: UW], m_last[p],
                             held[0].data, held[0].keep, held[0].user, held[0].last, $time);
                end
            end
        end
        acc = s_valid && exp_ready;
        if (held.size() != 0 && m_ready[held[0].port]) begin
            delivered[held[0].port]++;
            held.delete(0);
        end
        if (rst) begin
            held.delete();
            in_pkt   = 0;
            exp_asel = '0;
        end else if (acc) begin
            if (!in_pkt) begin
                if (int'(sel) < M) begin
                    pkt_port = int'(sel); pkt_drop = 0; exp_asel = sel;
                end else begin
`ifdef PACKET_DEMUX_DROP_EN
                    pkt_port = 0; pkt_drop = 1; exp_asel = sel;
`else
                    pkt_port = 0; pkt_drop = 0; exp_asel = '0;
`endif
                end
            end
            in_pkt = !s_last;
            if (!pkt_drop) held.push_back('{pkt_port, s_data, s_keep, s_user, s_last});
        end
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input logic last);
        s_valid = 1'b1;
        s_last  = last;
        s_data  = {$urandom(), $urandom()};
        s_keep  = KW'($urandom());
        s_user  = UW'($urandom());
        acc = 0;
        for (int n = 0; n < 64 && !acc; n++) step();
        tests++;
        if (!acc) begin
            failed++; $display("FAIL send_beat: beat not accepted, got 0 want 1 within 64 cycles");
        end
        s_valid = 1'b0;
    endtask

    task automatic drain();
        s_valid = 1'b0;
        m_ready = '1;
        repeat (4) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        step();
        step();
        tests++;
        if (m_valid !== '0 || busy !== 1'b0 || active_sel !== '0 || s_ready !== 1'b0) begin
            failed++;
            $display("FAIL reset_state: got valid=%b busy=%b asel=%0d rdy=%b want 0/0/0/0",
                     m_valid, busy, active_sel, s_ready);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int d[M];
        drain();
        foreach (d[i]) d[i] = delivered[i];
        sel = 2'd1;
        for (int b = 0; b < 4; b++) send_beat(b == 3);
        drain();
        tests++;
        if (delivered[1] - d[1] !== 4 || delivered[0] !== d[0] || delivered[2] !== d[2]) begin
            failed++;
            $display("FAIL basic_route: got p0=%0d p1=%0d p2=%0d want 0/4/0",
                     delivered[0]-d[0], delivered[1]-d[1], delivered[2]-d[2]);
        end
    endtask

    task automatic test_select_ignored();
        int d[M];
        drain();
        foreach (d[i]) d[i] = delivered[i];
        sel = 2'd0;
        send_beat(1'b0);
        send_beat(1'b0);
        sel = 2'd1;
        for (int b = 2; b < 5; b++) send_beat(b == 4);
        send_beat(1'b0);
        send_beat(1'b1);
        drain();
        tests++;
        if (delivered[0] - d[0] !== 5 || delivered[1] - d[1] !== 2) begin
            failed++;
            $display("FAIL select_ignored: got p0=%0d p1=%0d want 5/2", delivered[0]-d[0], delivered[1]-d[1]);
        end
    endtask

    task automatic test_backpressure();
        int d1;
        drain();
        d1  = delivered[1];
        sel = 2'd1;
        send_beat(1'b0);
        send_beat(1'b0);
        m_ready[1] = 1'b0;
        s_valid = 1'b1; s_last = 1'b0; s_data = {$urandom(), $urandom()};
        s_keep = KW'($urandom()); s_user = UW'($urandom());
        for (int c = 0; c < 3; c++) begin
            step();
            tests++;
            if (acc !== 1'b0 || s_ready !== 1'b0) begin
                failed++; $display("FAIL backpressure_stall: got acc=%b rdy=%b want 0/0", acc, s_ready);
            end
        end
        m_ready[1] = 1'b1;
        acc = 0;
        for (int n = 0; n < 8 && !acc; n++) step();
        tests++;
        if (!acc) begin
            failed++; $display("FAIL backpressure_resume: got 0 want 1");
        end
        s_valid = 1'b0;
        for (int b = 3; b < 6; b++) send_beat(b == 5);
        drain();
        tests++;
        if (delivered[1] - d1 !== 6) begin
            failed++; $display("FAIL backpressure_count: got %0d want 6", delivered[1]-d1);
        end
    endtask

    task automatic test_back_to_back();
        int d[M];
        int accepted = 0;
        drain();
        foreach (d[i]) d[i] = delivered[i];
        for (int k = 0; k < 8; k++) begin
            sel = SS'(k % 2);
            s_valid = 1'b1; s_last = 1'b1; s_data = {$urandom(), $urandom()};
            s_keep = KW'($urandom()); s_user = UW'($urandom());
            step();
            if (acc) accepted++;
            tests++;
            if (busy !== 1'b0) begin
                failed++; $display("FAIL b2b_busy: got %b want 0", busy);
            end
        end
        s_valid = 1'b0;
        drain();
        tests++;
        if (accepted !== 8 || delivered[0] - d[0] !== 4 || delivered[1] - d[1] !== 4) begin
            failed++;
            $display("FAIL b2b_throughput: got acc=%0d p0=%0d p1=%0d want 8/4/4",
                     accepted, delivered[0]-d[0], delivered[1]-d[1]);
        end
    endtask

    task automatic test_reset_mid();
        int d[M];
        drain();
        foreach (d[i]) d[i] = delivered[i];
        sel = 2'd0;
        send_beat(1'b0);
        send_beat(1'b0);
        s_valid = 1'b1; s_last = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        s_valid = 1'b0;
        tests++;
        if (m_valid !== '0 || busy !== 1'b0 || active_sel !== '0) begin
            failed++;
            $display("FAIL reset_mid: got valid=%b busy=%b asel=%0d want 0/0/0", m_valid, busy, active_sel);
        end
        sel = 2'd1;
        for (int b = 0; b < 4; b++) send_beat(b == 3);
        drain();
        tests++;
        if (delivered[1] - d[1] !== 4 || delivered[0] - d[0] !== 2) begin
            failed++;
            $display("FAIL reset_mid_route: got p0=%0d p1=%0d want 2/4", delivered[0]-d[0], delivered[1]-d[1]);
        end
    endtask

    task automatic test_out_of_range();
        int d[M];
        int want0;
        drain();
        foreach (d[i]) d[i] = delivered[i];
        sel = 2'd3;
        for (int b = 0; b < 3; b++) send_beat(b == 2);
        drain();
`ifdef PACKET_DEMUX_DROP_EN
        want0 = 0;
`else
        want0 = 3;
`endif
        tests++;
        if (delivered[0] - d[0] !== want0 || delivered[1] !== d[1] || delivered[2] !== d[2]) begin
            failed++;
            $display("FAIL out_of_range: got p0=%0d p1=%0d p2=%0d want %0d/0/0",
                     delivered[0]-d[0], delivered[1]-d[1], delivered[2]-d[2], want0);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst     = ($urandom_range(0, 99) == 0);
            sel     = SS'($urandom_range(0, 3));
            s_valid = ($urandom_range(0, 3) != 0);
            s_last  = ($urandom_range(0, 3) == 0);
            s_data  = {$urandom(), $urandom()};
            s_keep  = KW'($urandom());
            s_user  = UW'($urandom());
            m_ready = M'($urandom());
            step();
        end
        rst = 1'b0;
        drain();
        tests++;
        if (held.size() != 0 || m_valid !== '0) begin
            failed++; $display("FAIL random_drain: got valid=%b want 000", m_valid);
        end
    endtask

    initial begin
        rst = 1'b1; sel = '0; s_valid = 1'b0; s_last = 1'b0;
        s_data = '0; s_keep = '0; s_user = '0; m_ready = '1;
        foreach (delivered[i]) delivered[i] = 0;
        test_reset();
        test_basic();
        test_select_ignored();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_out_of_range();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
